// File: rtl/parking_pkg.sv
// Shared definitions for the car park occupancy tracker.
// Holds the capacity constants, the count and hour types, and the
// hour-to-university-capacity mapping used by parking_capacity.
package parking_pkg;

    typedef logic [9:0] count_t;
    typedef logic [4:0] hour_t;

    localparam count_t TOTAL_CAP   = 10'd700;
    localparam count_t UNI_CAP_MAX = 10'd500;
    localparam count_t UNI_CAP_MIN = 10'd200;
    localparam count_t UNI_STEP    = 10'd50;

    localparam hour_t  OPEN_HOUR   = 5'd8;
    localparam hour_t  STEP_HOUR   = 5'd13;
    localparam hour_t  FLAT_HOUR   = 5'd16;
    localparam hour_t  LAST_HOUR   = 5'd23;

    // University capacity for a given hour. Before STEP_HOUR (including the
    // closed night hours) the full allocation applies; from STEP_HOUR it
    // shrinks by UNI_STEP each hour, then drops to the floor at FLAT_HOUR.
    function automatic count_t uni_cap_for_hour(hour_t h);
        count_t steps;
        if (h < STEP_HOUR) begin
            return UNI_CAP_MAX;
        end else if (h >= FLAT_HOUR) begin
            return UNI_CAP_MIN;
        end else begin
            steps = {5'd0, h - STEP_HOUR} + 10'd1;
            return UNI_CAP_MAX - (UNI_STEP * steps);
        end
    endfunction

endpackage

// File: rtl/parking_management_if.sv
// Gate-sensor / display-board bundle of the car park tracker.
//  car_entered, is_uni_car_entered : entry event and its class (1 = uni)
//  car_exited, is_uni_car_exited   : exit event and its class (1 = uni)
//  hour                            : current hour 0..23
//  uni_parked_car, parked_car      : uni / non-uni occupancy counts
//  uni_vacated_space, vacated_space: free uni / non-uni spaces
//  uni_is_vacated_space, is_vacated_space : nonzero-vacancy flags
// Event signals are levels sampled on every rising clock edge; there is no
// handshake: an event present at an edge is either applied or dropped on
// that same edge, and the outputs are always valid.
// master = sensor/display side, slave = the tracker.
interface parking_management_if;
    import parking_pkg::*;

    logic   car_entered;
    logic   is_uni_car_entered;
    logic   car_exited;
    logic   is_uni_car_exited;
    hour_t  hour;
    count_t uni_parked_car;
    count_t parked_car;
    count_t uni_vacated_space;
    count_t vacated_space;
    logic   uni_is_vacated_space;
    logic   is_vacated_space;

    modport master (
        output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited, hour,
        input  uni_parked_car, parked_car, uni_vacated_space, vacated_space,
               uni_is_vacated_space, is_vacated_space
    );

    modport slave (
        input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited, hour,
        output uni_parked_car, parked_car, uni_vacated_space, vacated_space,
               uni_is_vacated_space, is_vacated_space
    );

endinterface

// File: rtl/parking_capacity.sv
// Combinational hour decoder: splits the total capacity between university
// and non-university cars and reports whether entries are allowed.
//  hour_i    : current hour
//  uni_cap_o : university capacity for this hour
//  gen_cap_o : non-university capacity (TOTAL_CAP - uni_cap_o)
//  open_o    : 1 while OPEN_HOUR <= hour_i <= LAST_HOUR
module parking_capacity
    import parking_pkg::*;
(
    input  hour_t  hour_i,
    output count_t uni_cap_o,
    output count_t gen_cap_o,
    output logic   open_o
);

    count_t uni_cap;

    assign uni_cap   = uni_cap_for_hour(hour_i);
    assign uni_cap_o = uni_cap;
    assign gen_cap_o = TOTAL_CAP - uni_cap;
    // Out-of-range hours (24..31) count as closed.
    assign open_o    = (hour_i >= OPEN_HOUR) && (hour_i <= LAST_HOUR);

endmodule

// File: rtl/parking_management.sv
// Occupancy tracker for a 700-space mixed university / public car park.
// Counts university and non-university cars separately, accepts entries
// only against the hour-dependent capacity split, and reports free spaces.
//  clk   : rising-edge clock
//  reset : asynchronous active-low reset, clears both counts
//  bus   : sensor inputs and display outputs (parking_management_if.slave)
module parking_management
    import parking_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    parking_management_if.slave  bus
);

    count_t uni_cap;
    count_t gen_cap;
    logic   open_now;

    count_t uni_q, uni_d;
    count_t gen_q, gen_d;

    logic   uni_in, uni_out;
    logic   gen_in, gen_out;

    parking_capacity u_capacity (
        .hour_i    (bus.hour),
        .uni_cap_o (uni_cap),
        .gen_cap_o (gen_cap),
        .open_o    (open_now)
    );

    // Accept decisions all use the pre-edge counts, so a same-class entry
    // and exit on one edge are judged independently of each other.
    assign uni_in  = bus.car_entered &&  bus.is_uni_car_entered && open_now && (uni_q < uni_cap);
    assign gen_in  = bus.car_entered && !bus.is_uni_car_entered && open_now && (gen_q < gen_cap);
    assign uni_out = bus.car_exited  &&  bus.is_uni_car_exited  && (uni_q != '0);
    assign gen_out = bus.car_exited  && !bus.is_uni_car_exited  && (gen_q != '0);

    always_comb begin
        uni_d = uni_q;
        if (uni_in && !uni_out) begin
            uni_d = uni_q + 10'd1;
        end else if (!uni_in && uni_out) begin
            uni_d = uni_q - 10'd1;
        end
    end

    always_comb begin
        gen_d = gen_q;
        if (gen_in && !gen_out) begin
            gen_d = gen_q + 10'd1;
        end else if (!gen_in && gen_out) begin
            gen_d = gen_q - 10'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uni_q <= '0;
            gen_q <= '0;
        end else begin
            uni_q <= uni_d;
            gen_q <= gen_d;
        end
    end

    // Capacity may shrink below occupancy later in the day; cars are never
    // evicted, so vacancy saturates at zero instead of wrapping.
    assign bus.uni_parked_car       = uni_q;
    assign bus.parked_car           = gen_q;
    assign bus.uni_vacated_space    = (uni_cap > uni_q) ? (uni_cap - uni_q) : '0;
    assign bus.vacated_space        = (gen_cap > gen_q) ? (gen_cap - gen_q) : '0;
    assign bus.uni_is_vacated_space = (bus.uni_vacated_space != '0);
    assign bus.is_vacated_space     = (bus.vacated_space != '0);

endmodule

// File: tb/tb_parking_management.sv
module tb_parking_management;
    import parking_pkg::*;

    typedef logic [41:0] snap_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    parking_management_if bus ();

    parking_management dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    snap_t exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic snap_t actual_snap();
        return {bus.uni_parked_car, bus.parked_car, bus.uni_vacated_space,
                bus.vacated_space, bus.uni_is_vacated_space, bus.is_vacated_space};
    endfunction

    // Flags are 1 exactly when the hand-given vacancy is nonzero.
    task automatic expect_state(input string nm, input count_t u, input count_t g,
                                input count_t uv, input count_t gv);
        exp_q.push_back({u, g, uv, gv, (uv != 10'd0), (gv != 10'd0)});
        name_q.push_back(nm);
    endtask

    // ---------------- driver ----------------
    // Inputs change just after a falling edge, are sampled at the next
    // rising edge, and events are cleared right after it (hour is kept).
    task automatic step(input logic ent, input logic ue, input logic ex,
                        input logic ux, input hour_t hr);
        @(negedge clk);
        #1;
        bus.car_entered        = ent;
        bus.is_uni_car_entered = ue;
        bus.car_exited         = ex;
        bus.is_uni_car_exited  = ux;
        bus.hour               = hr;
        @(posedge clk);
        #1;
        bus.car_entered = 1'b0;
        bus.car_exited  = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        snap_t e;
        snap_t a;
        string nm;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = actual_snap();
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got uni=%0d gen=%0d uvac=%0d gvac=%0d flags=%b%b, expected uni=%0d gen=%0d uvac=%0d gvac=%0d flags=%b%b",
                             nm, a[41:32], a[31:22], a[21:12], a[11:2], a[1], a[0],
                             e[41:32], e[31:22], e[21:12], e[11:2], e[1], e[0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset                  = 1'b0;
        bus.car_entered        = 1'b0;
        bus.is_uni_car_entered = 1'b0;
        bus.car_exited         = 1'b0;
        bus.is_uni_car_exited  = 1'b0;
        bus.hour               = 5'd8;

        expect_state("reset_state", 0, 0, 500, 200);
        @(negedge clk);
        #1 reset = 1'b1;

        // closed hour: entry ignored
        step(1, 1, 0, 0, 5'd7);
        expect_state("closed_entry", 0, 0, 500, 200);

        // basic entry / exit at hour 8
        step(1, 1, 0, 0, 5'd8);
        expect_state("uni_entry", 1, 0, 499, 200);
        step(0, 0, 1, 1, 5'd8);
        expect_state("uni_exit", 0, 0, 500, 200);
        step(1, 0, 0, 0, 5'd8);
        expect_state("gen_entry", 0, 1, 500, 199);
        step(0, 0, 1, 0, 5'd8);
        expect_state("gen_exit", 0, 0, 500, 200);
        step(0, 0, 1, 1, 5'd8);
        expect_state("uni_exit_at_zero", 0, 0, 500, 200);
        step(0, 0, 1, 0, 5'd8);
        expect_state("gen_exit_at_zero", 0, 0, 500, 200);

        // capacity steps
        step(1, 1, 0, 0, 5'd13);
        expect_state("hour13_entry", 1, 0, 449, 250);
        step(1, 1, 0, 0, 5'd15);
        expect_state("hour15_entry", 2, 0, 348, 350);
        step(1, 1, 0, 0, 5'd16);
        expect_state("hour16_entry", 3, 0, 197, 500);

        // uni saturation at hour 13
        for (int i = 0; i < 510; i++) step(1, 1, 0, 0, 5'd13);
        expect_state("uni_saturate_450", 450, 0, 0, 250);

        // non-uni saturation at hour 8
        for (int i = 0; i < 200; i++) step(1, 0, 0, 0, 5'd8);
        expect_state("gen_fill_200", 450, 200, 50, 0);
        step(1, 0, 0, 0, 5'd8);
        expect_state("gen_full_reject", 450, 200, 50, 0);

        // capacity below occupancy at hour 15 (uni cap 350)
        step(1, 1, 0, 0, 5'd15);
        expect_state("shrink_uni_reject", 450, 200, 0, 150);
        step(0, 0, 1, 1, 5'd15);
        expect_state("shrink_uni_exit", 449, 200, 0, 150);
        step(1, 0, 0, 0, 5'd15);
        expect_state("hour15_gen_entry", 449, 201, 0, 149);
        step(0, 0, 1, 0, 5'd15);
        expect_state("hour15_gen_exit", 449, 200, 0, 150);

        // simultaneous entry and exit
        step(1, 1, 1, 1, 5'd8);
        expect_state("same_uni_both", 449, 200, 51, 0);
        step(1, 1, 1, 1, 5'd15);
        expect_state("same_uni_entry_rejected", 448, 200, 0, 150);
        step(1, 1, 1, 0, 5'd8);
        expect_state("diff_class", 449, 199, 51, 1);
        step(1, 0, 1, 0, 5'd8);
        expect_state("same_gen_both", 449, 199, 51, 1);

        // asynchronous reset between clock edges
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (bus.uni_parked_car !== 10'd0 || bus.parked_car !== 10'd0) begin
            n_fail++;
            $display("FAIL async_reset: got uni=%0d gen=%0d, expected uni=0 gen=0",
                     bus.uni_parked_car, bus.parked_car);
        end
        step(1, 1, 0, 0, 5'd8);
        expect_state("reset_hold_entry", 0, 0, 500, 200);
        @(negedge clk);
        #1 reset = 1'b1;

        // operation after reset, late and night hours
        step(1, 1, 0, 0, 5'd8);
        expect_state("post_reset_entry", 1, 0, 499, 200);
        step(0, 0, 0, 0, 5'd14);
        expect_state("hour14_caps", 1, 0, 399, 300);
        step(1, 1, 0, 0, 5'd23);
        expect_state("hour23_entry", 2, 0, 198, 500);
        step(0, 0, 1, 1, 5'd0);
        expect_state("hour0_exit", 1, 0, 499, 200);
        step(1, 0, 0, 0, 5'd0);
        expect_state("hour0_gen_entry_ignored", 1, 0, 499, 200);

        // drain the scoreboard, bounded
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
